edge_detect_multi: RTL
======================

// Module: edge_detect_multi
// PURPOSE
//   Multi-channel, parametrised successor to the single-bit rising/falling edge detector.
//   Per channel: synchronise async input -> deglitch filter -> one-cycle rise/fall pulses.
//   Per-channel mode selects which edges set a sticky event flag.
//   Flags are software-clearable and OR-reduced into one interrupt line for the CPU/IRQ block.
// PARAMETERS
//   NUM_CH         4   number of independent input channels (>=1)
//   SYNC_STAGES    2   synchroniser flops per channel (>=2)
//   FILTER_CYCLES  3   consecutive stable cycles needed to accept a new level (>=1)
//   CNT_W          $clog2(FILTER_CYCLES+1)  filter counter width (derived, localparam)
// PORTS
//   clk             in   1         system clock, all logic on rising edge
//   reset_n         in   1         asynchronous, active-low reset
//   a_i             in   NUM_CH    asynchronous level inputs
//   mode_i          in   2*NUM_CH  per-channel mode [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clear_i         in   NUM_CH    per-channel sticky-flag clear, one-cycle strobe
//   rising_edge_o   out  NUM_CH    one-cycle pulse on accepted 0->1 (not masked by mode)
//   falling_edge_o  out  NUM_CH    one-cycle pulse on accepted 1->0 (not masked by mode)
//   event_o         out  NUM_CH    sticky flag, set by mode-qualified edges
//   irq_o           out  1         |event_o
// BEHAVIOUR
//   Reset (async assert, sync-to-clk deassert external): sync flops, filtered level, counters,
//     rising_edge_o, falling_edge_o, event_o all 0; irq_o 0.
//   Sync: s = last stage of SYNC_STAGES-flop chain on a_i[i].
//   Filter (per channel, filt = accepted level, cnt = counter):
//     s == filt                              -> cnt <= 0
//     s != filt, cnt <  FILTER_CYCLES-1      -> cnt <= cnt+1
//     s != filt, cnt == FILTER_CYCLES-1      -> filt <= s, cnt <= 0, edge pulse registered
//   Pulses: rising_edge_o[i] <= (accept & s); falling_edge_o[i] <= (accept & ~s); else 0.
//     Exactly one cycle wide, never both in same cycle on one channel.
//   Latency: a_i step held stable -> pulse high SYNC_STAGES+FILTER_CYCLES clocks after
//     first sampling edge (defaults: 5).
//   Glitch rejection: any excursion shorter than FILTER_CYCLES cycles at s gives no pulse;
//     counter restarts from 0 when s returns to filt.
//   Sticky flag: set = (rise & mode[0]) | (fall & mode[1]), using the same-cycle pulse term.
//     set & clear_i same cycle -> flag stays/becomes 1 (set wins, no lost event).
//     clear_i without set -> 0 next cycle. mode 00 -> flag never sets; pulses still output.
//     mode_i changes take effect on the next edge; they do not touch existing flags.
//   Input high out of reset: filt starts 0, so a rising pulse fires after full latency.
//   Reset mid-operation: all state cleared immediately; pending filter counts discarded.
//   Channels fully independent; simultaneous edges on several channels all reported.
// STRUCTURE
//   Package edge_pkg: localparams MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10,
//     MODE_BOTH=2'b11.
//   Sub-module edge_chan: sync chain + filter + pulse + sticky flag for one channel.
//     Top instantiates it NUM_CH times in a generate loop; top holds only irq_o OR.
// TESTING
//   1 reset: reset_n=0 with a_i=4'hF -> all outputs 0; release -> rising_edge_o=4'hF
//     for exactly 1 cycle, 5 clocks after first sample.
//   2 ch0 mode=01, a_i[0] 0->1 held -> rising_edge_o[0] one pulse at +5, event_o[0]=1,
//     irq_o=1; 1->0 -> falling_edge_o[0] pulse, event_o unchanged.
//   3 glitch: a_i[1] high for 2 cycles (FILTER_CYCLES=3) -> no pulse, event_o[1]=0;
//     high for 3 cycles -> rise then fall pulses.
//   4 mode=11 on ch2, toggle twice -> 2 rise + 2 fall pulses; clear_i[2] -> event_o[2]=0.
//   5 clear_i[3] in same cycle as qualifying edge -> event_o[3] stays 1.
//   6 reset_n asserted mid-filter (cnt=2) -> no pulse after release until a fresh full
//     latency; mode=00 channel pulses but irq_o stays 0.

Source files
------------

// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared mode encodings for the multi-channel edge detector
package edge_pkg;
   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;
endpackage

// File: rtl/edge_chan.sv
// rtl/edge_chan.sv - one channel: synchroniser, deglitch filter, edge pulses, sticky flag
module edge_chan
   import edge_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       a,
   input  logic [1:0] mode,
   input  logic       clear,
   output logic       rising_edge,
   output logic       falling_edge,
   output logic       event_flag
);
   localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   filt_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   s;
   logic                   accept;
   logic                   rise_d;
   logic                   fall_d;
   logic                   set;

   always_comb begin
      s      = sync_q[SYNC_STAGES-1];
      accept = (s != filt_q) && (cnt_q == CNT_LAST);
      rise_d = accept & s;
      fall_d = accept & ~s;
      // Flag follows the pulse being registered this cycle, so it rises with the pulse
      set    = (rise_d & |(mode & MODE_RISE)) | (fall_d & |(mode & MODE_FALL));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], a};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q <= 1'b0;
         cnt_q  <= '0;
      end else if (s == filt_q) begin
         cnt_q  <= '0;
      end else if (accept) begin
         filt_q <= s;
         cnt_q  <= '0;
      end else begin
         cnt_q  <= cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rising_edge  <= 1'b0;
         falling_edge <= 1'b0;
         event_flag   <= 1'b0;
      end else begin
         rising_edge  <= rise_d;
         falling_edge <= fall_d;
         // Set dominates clear so an edge coinciding with a clear is never lost
         event_flag   <= (event_flag & ~clear) | set;
      end
   end
endmodule

// File: rtl/edge_detect_multi.sv
// rtl/edge_detect_multi.sv - NUM_CH independent edge channels with a combined interrupt
module edge_detect_multi
   import edge_pkg::*;
#(
   parameter int NUM_CH        = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 3
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_CH-1:0]   a_i,
   input  logic [2*NUM_CH-1:0] mode_i,
   input  logic [NUM_CH-1:0]   clear_i,
   output logic [NUM_CH-1:0]   rising_edge_o,
   output logic [NUM_CH-1:0]   falling_edge_o,
   output logic [NUM_CH-1:0]   event_o,
   output logic                irq_o
);
   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      edge_chan #(
         .SYNC_STAGES  (SYNC_STAGES),
         .FILTER_CYCLES(FILTER_CYCLES)
      ) u_chan (
         .clk         (clk),
         .reset_n     (reset_n),
         .a           (a_i[i]),
         .mode        (mode_i[2*i+1:2*i]),
         .clear       (clear_i[i]),
         .rising_edge (rising_edge_o[i]),
         .falling_edge(falling_edge_o[i]),
         .event_flag  (event_o[i])
      );
   end

   assign irq_o = |event_o;
endmodule
